freq_generator: RTL

//  Programmable square-wave source: emits signal_out with period DIV clk cycles, high HIGH cycles.

---
 rtl/freq_generator.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/freq_generator.sv
// Programmable square-wave source with period/high-time config applied at period boundaries.
// Optional burst mode enabled by defining FREQ_GEN_BURST_EN (adds burst_len / burst_done).
module freq_generator #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_DIV  = 100,
    parameter int unsigned DEFAULT_HIGH = 50
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0]      burst_len,
    output logic             burst_done,
`endif
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             signal_out,
    output logic             period_tick,
    output logic [31:0]      period_count
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   high_q, high_d;
    logic               pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0]   pend_div_q, pend_div_d;
    logic [WIDTH-1:0]   pend_high_q, pend_high_d;
    logic               sig_q, sig_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept_c;
    logic               cfg_ok_c;
    logic [WIDTH-1:0]   high_clamp_c;
    logic               wrap_c;
    logic               burst_end_c;
    logic               start_ok_c;

    assign accept_c     = cfg_valid & ~pend_valid_q;
    assign cfg_ok_c     = (cfg_div >= WIDTH'(2));
    assign high_clamp_c = (cfg_high == '0)     ? WIDTH'(1) :
                          (cfg_high >= cfg_div) ? (cfg_div - WIDTH'(1)) : cfg_high;
    assign wrap_c       = (state_q != IDLE) && (cnt_q == (div_q - WIDTH'(1)));

    assign cfg_ready    = ~pend_valid_q;
    assign cfg_err      = err_q;
    assign signal_out   = sig_q;
    assign period_tick  = wrap_c;
    assign period_count = count_q;

`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_rem_q;
    logic        burst_on_q;
    logic        rearm_q;
    logic        done_q;

    assign burst_end_c = wrap_c & burst_on_q & (burst_rem_q == 16'd1);
    assign start_ok_c  = ~rearm_q;
    assign burst_done  = done_q;

    // Burst period counter; after a burst, enable must drop before the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_rem_q <= '0;
            burst_on_q  <= 1'b0;
            rearm_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= burst_end_c;
            if ((state_q == IDLE) && enable && !rearm_q) begin
                burst_on_q  <= (burst_len != 16'd0);
                burst_rem_q <= burst_len;
            end else if (burst_end_c) begin
                burst_on_q  <= 1'b0;
                burst_rem_q <= '0;
            end else if (wrap_c && burst_on_q) begin
                burst_rem_q <= burst_rem_q - 16'd1;
            end
            if (burst_end_c) begin
                rearm_q <= 1'b1;
            end else if (!enable) begin
                rearm_q <= 1'b0;
            end
        end
    end
`else
    assign burst_end_c = 1'b0;
    assign start_ok_c  = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= WIDTH'(DEFAULT_DIV);
            high_q       <= WIDTH'(DEFAULT_HIGH);
            pend_valid_q <= 1'b0;
            pend_div_q   <= '0;
            pend_high_q  <= '0;
            sig_q        <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            high_q       <= high_d;
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
            pend_high_q  <= pend_high_d;
            sig_q        <= sig_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        high_d       = high_q;
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        pend_high_d  = pend_high_q;
        sig_d        = sig_q;
        err_d        = accept_c & ~cfg_ok_c;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                sig_d = 1'b0;
                // A config accepted on the final wrap into IDLE lands in pending; flush it here.
                if (pend_valid_q) begin
                    div_d        = pend_div_q;
                    high_d       = pend_high_q;
                    pend_valid_d = 1'b0;
                end
                if (accept_c && cfg_ok_c) begin
                    div_d  = cfg_div;
                    high_d = high_clamp_c;
                end
                if (enable && start_ok_c) begin
                    state_d = RUN;
                    sig_d   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (accept_c && cfg_ok_c) begin
                    pend_valid_d = 1'b1;
                    pend_div_d   = cfg_div;
                    pend_high_d  = high_clamp_c;
                end
                if (wrap_c) begin
                    cnt_d   = '0;
                    count_d = count_q + CNT_W'(1);
                    if (pend_valid_q) begin
                        div_d        = pend_div_q;
                        high_d       = pend_high_q;
                        pend_valid_d = 1'b0;
                    end
                    // High time is always >= 1, so a new period always starts high.
                    if (enable && !burst_end_c) begin
                        state_d = RUN;
                        sig_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sig_d   = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_q + WIDTH'(1);
                    sig_d   = ((cnt_q + WIDTH'(1)) < high_q);
                    state_d = enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sig_d   = 1'b0;
            end
        endcase
    end

endmodule
